// File: rtl/irq_request_collector.sv
// IF (0xFF0F) request collector: sticky interrupt flags fed by VBlank/STAT edges, timer/serial
// pulses and a debounced joypad, with CPU read/write access and ack clearing from the IRQ stage.
module irq_request_collector #(
  parameter logic [15:0] IF_ADDR  = 16'hFF0F,
  parameter int          SYNC_LEN = 2,
  parameter int          DEBOUNCE = 16
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic        RD,
  input  logic        WR,
  input  logic        VBLANK,
  input  logic        STAT_LINE,
  input  logic        TIMER_REQ,
  input  logic        SERIAL_REQ,
  input  logic [3:0]  JOYP_IN,
  input  logic [7:0]  CPU_IRQ_ACK,
  output logic [7:0]  CPU_IRQ_TRIG
);

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

  typedef enum logic [1:0] {RELEASED, FILTER, PRESSED} joy_state_t;

  logic [4:0]                if_q;
  logic [4:0]                if_nxt;
  logic [4:0]                set_ev;
  logic                      vblank_prev;
  logic                      stat_prev;
  logic [SYNC_LEN-1:0][3:0]  sync_q;
  logic [3:0]                j;
  logic                      any_low;
  joy_state_t                joy_state;
  logic [CW-1:0]             cnt;
  logic                      joy_req;
  logic                      wr_hit;
  logic                      unused_bits;

  assign unused_bits = ^{D_IN[7:5], CPU_IRQ_ACK[7:5]};

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= JOYP_IN;
      for (int i = 1; i < SYNC_LEN; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign j       = sync_q[SYNC_LEN-1];
  assign any_low = ~&j;

  // Request is decoded from the FSM flops and the synchronised lines, so it is glitch-free.
  always_comb begin
    joy_req = 1'b0;
    case (joy_state)
      RELEASED: joy_req = any_low && (DEBOUNCE == 0);
      FILTER:   joy_req = any_low && (cnt == CNT_LAST);
      default:  joy_req = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      joy_state <= RELEASED;
      cnt       <= '0;
    end else begin
      case (joy_state)
        RELEASED: begin
          if (any_low) begin
            if (DEBOUNCE == 0) begin
              joy_state <= PRESSED;
            end else begin
              joy_state <= FILTER;
              cnt       <= '0;
            end
          end
        end
        FILTER: begin
          if (!any_low)              joy_state <= RELEASED;
          else if (cnt == CNT_LAST)  joy_state <= PRESSED;
          else                       cnt       <= cnt + 1'b1;
        end
        PRESSED: begin
          if (!any_low) joy_state <= RELEASED;
        end
        default: joy_state <= RELEASED;
      endcase
    end
  end

  assign wr_hit = WR && (A == IF_ADDR);
  assign set_ev = {joy_req, SERIAL_REQ, TIMER_REQ, STAT_LINE & ~stat_prev, VBLANK & ~vblank_prev};

  // Sets are OR-ed last so an event in the same cycle as a write or ack is never lost.
  always_comb begin
    if_nxt = wr_hit ? D_IN[4:0] : if_q;
    if_nxt = if_nxt & ~CPU_IRQ_ACK[4:0];
    if_nxt = if_nxt | set_ev;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      if_q        <= '0;
      vblank_prev <= 1'b0;
      stat_prev   <= 1'b0;
    end else begin
      if_q        <= if_nxt;
      vblank_prev <= VBLANK;
      stat_prev   <= STAT_LINE;
    end
  end

  assign CPU_IRQ_TRIG = {3'b000, if_q};
  assign D_OUT        = {3'b111, if_q};
  assign D_OE         = RD && (A == IF_ADDR) && nRESET;

endmodule
